// File: rtl/wifi_tx_pkg.sv
// Shared definitions for the legacy 802.11a TX preamble generator.
// Holds the FSM state codes, the ROM section selector and section lengths.
package wifi_tx_pkg;

    localparam int STF_LEN    = 16;
    localparam int LTF_LEN    = 64;
    localparam int LTF_GI_LEN = 32;
    localparam int ROM_W      = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STF    = 3'd1,
        ST_LTF_GI = 3'd2,
        ST_LTF    = 3'd3,
        ST_TAIL   = 3'd4,
        ST_DONE   = 3'd5
    } pre_state_e;

    typedef enum logic {
        SEC_STF = 1'b0,
        SEC_LTF = 1'b1
    } rom_sec_e;

endpackage

// File: rtl/wifi_tx_preamble_rom.sv
// Combinational preamble sample tables (12-bit signed re/im, scaled by 512).
// Ports:
//   i_sec  - table select (STF or LTF)
//   i_idx  - sample index (STF uses bits [3:0], LTF uses all 6 bits)
//   o_re   - real part
//   o_im   - imaginary part
module wifi_tx_preamble_rom
    import wifi_tx_pkg::*;
(
    input  rom_sec_e                i_sec,
    input  logic [5:0]              i_idx,
    output logic signed [ROM_W-1:0] o_re,
    output logic signed [ROM_W-1:0] o_im
);
    logic [2*ROM_W-1:0] w_stf;
    logic [2*ROM_W-1:0] w_ltf;

    always_comb begin
        w_stf = '0;
        case (i_idx[3:0])
            4'd0:  w_stf = {12'sd24, 12'sd24};   4'd1:  w_stf = {-12'sd68, 12'sd1};
            4'd2:  w_stf = {-12'sd7, -12'sd40};  4'd3:  w_stf = {12'sd73, -12'sd7};
            4'd4:  w_stf = {12'sd47, 12'sd0};    4'd5:  w_stf = {12'sd73, -12'sd7};
            4'd6:  w_stf = {-12'sd7, -12'sd40};  4'd7:  w_stf = {-12'sd68, 12'sd1};
            4'd8:  w_stf = {12'sd24, 12'sd24};   4'd9:  w_stf = {12'sd1, -12'sd68};
            4'd10: w_stf = {-12'sd40, -12'sd7};  4'd11: w_stf = {-12'sd7, 12'sd73};
            4'd12: w_stf = {12'sd0, 12'sd47};    4'd13: w_stf = {-12'sd7, 12'sd73};
            4'd14: w_stf = {-12'sd40, -12'sd7};  4'd15: w_stf = {12'sd1, -12'sd68};
            default: w_stf = '0;
        endcase
    end

    always_comb begin
        w_ltf = '0;
        case (i_idx)
            6'd0:  w_ltf = {12'sd80, 12'sd0};    6'd1:  w_ltf = {-12'sd3, -12'sd61};
            6'd2:  w_ltf = {12'sd20, -12'sd57};  6'd3:  w_ltf = {12'sd50, 12'sd42};
            6'd4:  w_ltf = {12'sd11, 12'sd14};   6'd5:  w_ltf = {12'sd31, -12'sd45};
            6'd6:  w_ltf = {-12'sd59, -12'sd28}; 6'd7:  w_ltf = {-12'sd19, -12'sd54};
            6'd8:  w_ltf = {12'sd50, -12'sd13};  6'd9:  w_ltf = {12'sd27, 12'sd2};
            6'd10: w_ltf = {12'sd1, -12'sd59};   6'd11: w_ltf = {-12'sd70, -12'sd24};
            6'd12: w_ltf = {12'sd12, -12'sd30};  6'd13: w_ltf = {12'sd30, -12'sd8};
            6'd14: w_ltf = {-12'sd11, 12'sd82};  6'd15: w_ltf = {12'sd61, -12'sd2};
            6'd16: w_ltf = {12'sd32, 12'sd32};   6'd17: w_ltf = {12'sd19, -12'sd50};
            6'd18: w_ltf = {-12'sd29, -12'sd20}; 6'd19: w_ltf = {-12'sd67, -12'sd33};
            6'd20: w_ltf = {12'sd42, -12'sd47};  6'd21: w_ltf = {12'sd36, -12'sd7};
            6'd22: w_ltf = {-12'sd31, -12'sd41}; 6'd23: w_ltf = {-12'sd29, 12'sd11};
            6'd24: w_ltf = {-12'sd18, 12'sd77};  6'd25: w_ltf = {-12'sd62, 12'sd9};
            6'd26: w_ltf = {-12'sd65, 12'sd11};  6'd27: w_ltf = {12'sd38, 12'sd38};
            6'd28: w_ltf = {-12'sd2, -12'sd28};  6'd29: w_ltf = {-12'sd47, 12'sd59};
            6'd30: w_ltf = {12'sd47, 12'sd54};   6'd31: w_ltf = {12'sd6, 12'sd50};
            6'd32: w_ltf = {-12'sd80, 12'sd0};   6'd33: w_ltf = {12'sd6, -12'sd50};
            6'd34: w_ltf = {12'sd47, -12'sd54};  6'd35: w_ltf = {-12'sd47, -12'sd59};
            6'd36: w_ltf = {-12'sd2, 12'sd28};   6'd37: w_ltf = {12'sd38, -12'sd38};
            6'd38: w_ltf = {-12'sd65, -12'sd11}; 6'd39: w_ltf = {-12'sd62, -12'sd9};
            6'd40: w_ltf = {-12'sd18, -12'sd77}; 6'd41: w_ltf = {-12'sd29, -12'sd11};
            6'd42: w_ltf = {-12'sd31, 12'sd41};  6'd43: w_ltf = {12'sd36, 12'sd7};
            6'd44: w_ltf = {12'sd42, 12'sd47};   6'd45: w_ltf = {-12'sd67, 12'sd33};
            6'd46: w_ltf = {-12'sd29, 12'sd20};  6'd47: w_ltf = {12'sd19, 12'sd50};
            6'd48: w_ltf = {12'sd32, -12'sd32};  6'd49: w_ltf = {12'sd61, 12'sd2};
            6'd50: w_ltf = {-12'sd11, -12'sd82}; 6'd51: w_ltf = {12'sd30, 12'sd8};
            6'd52: w_ltf = {12'sd12, 12'sd30};   6'd53: w_ltf = {-12'sd70, 12'sd24};
            6'd54: w_ltf = {12'sd1, 12'sd59};    6'd55: w_ltf = {12'sd27, -12'sd2};
            6'd56: w_ltf = {12'sd50, 12'sd13};   6'd57: w_ltf = {-12'sd19, 12'sd54};
            6'd58: w_ltf = {-12'sd59, 12'sd28};  6'd59: w_ltf = {12'sd31, 12'sd45};
            6'd60: w_ltf = {12'sd11, -12'sd14};  6'd61: w_ltf = {12'sd50, -12'sd42};
            6'd62: w_ltf = {12'sd20, 12'sd57};   6'd63: w_ltf = {-12'sd3, 12'sd61};
            default: w_ltf = '0;
        endcase
    end

    assign o_re = (i_sec == SEC_LTF) ? w_ltf[2*ROM_W-1:ROM_W] : w_stf[2*ROM_W-1:ROM_W];
    assign o_im = (i_sec == SEC_LTF) ? w_ltf[ROM_W-1:0]       : w_stf[ROM_W-1:0];

endmodule

// File: rtl/wifi_tx_preamble_gen.sv
// Legacy 802.11a preamble generator: streams STF and optionally GI2 + LTF
// as complex samples with valid/ready backpressure and an early IFFT data request.
// Optional feature macro: WIFI_PRE_WINDOW_EN (halves the first STF sample and
// appends one halved tail sample).
// Ports:
//   i_clk, i_reset            - clock, async active-low reset
//   i_start, i_ltf_sel        - burst request (IDLE only), LTF include select
//   i_abort                   - synchronous abort, any state
//   i_out_ready               - downstream ready
//   o_out_valid, o_out_re/im  - sample stream (registered)
//   o_busy, o_data_req, o_done- status
//
// state     | meaning
// ST_IDLE   | waiting for start, outputs zero
// ST_STF    | short training field, STF_REPS x 16 samples
// ST_LTF_GI | 32-sample guard interval (LTF[32..63])
// ST_LTF    | LTF_REPS x 64-sample long training symbols
// ST_TAIL   | one halved window sample (windowed build only)
// ST_DONE   | one-cycle done pulse, outputs zero
module wifi_tx_preamble_gen
    import wifi_tx_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int STF_REPS  = 10,
    parameter int LTF_REPS  = 2,
    parameter int IFFT_LEAD = 48
)(
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic                     i_ltf_sel,
    input  logic                     i_abort,
    input  logic                     i_out_ready,
    output logic                     o_out_valid,
    output logic signed [DATA_W-1:0] o_out_re,
    output logic signed [DATA_W-1:0] o_out_im,
    output logic                     o_busy,
    output logic                     o_data_req,
    output logic                     o_done
);
    localparam int CNT_W = 8;
    localparam int REM_W = 10;
    localparam int SHIFT = DATA_W - ROM_W;
`ifdef WIFI_PRE_WINDOW_EN
    localparam int         WIN_EXTRA = 1;
    localparam pre_state_e ST_AFTER  = ST_TAIL;
`else
    localparam int         WIN_EXTRA = 0;
    localparam pre_state_e ST_AFTER  = ST_DONE;
`endif
    localparam int STF_SEC = STF_LEN * STF_REPS;
    localparam int LTF_SEC = LTF_LEN * LTF_REPS;
    localparam logic [REM_W-1:0] N_STF  = REM_W'(STF_SEC + WIN_EXTRA);
    localparam logic [REM_W-1:0] N_FULL = REM_W'(STF_SEC + LTF_GI_LEN + LTF_SEC + WIN_EXTRA);
    localparam logic [REM_W-1:0] LEAD_C = REM_W'(IFFT_LEAD);

    pre_state_e               r_state, w_state_nxt;
    logic [CNT_W-1:0]         r_cnt, w_cnt_nxt, w_sec_last;
    logic [REM_W-1:0]         r_rem, w_rem_nxt;
    logic                     r_ltf, w_ltf_nxt;
    logic                     r_out_valid;
    logic signed [DATA_W-1:0] r_out_re, r_out_im;
    logic                     w_fire, w_load, w_half, w_data_st;
    rom_sec_e                 w_rom_sec;
    logic [5:0]               w_rom_idx;
    logic signed [ROM_W-1:0]  w_rom_re, w_rom_im;
    logic signed [DATA_W-1:0] w_ext_re, w_ext_im, w_re_nxt, w_im_nxt;

    assign w_fire = r_out_valid & i_out_ready;

    always_comb begin
        w_sec_last = '0;
        case (r_state)
            ST_STF:    w_sec_last = CNT_W'(STF_SEC - 1);
            ST_LTF_GI: w_sec_last = CNT_W'(LTF_GI_LEN - 1);
            ST_LTF:    w_sec_last = CNT_W'(LTF_SEC - 1);
            default:   w_sec_last = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rem_nxt   = r_rem;
        w_ltf_nxt   = r_ltf;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_STF;
                    w_cnt_nxt   = '0;
                    w_ltf_nxt   = i_ltf_sel;
                    w_rem_nxt   = i_ltf_sel ? N_FULL : N_STF;
                    w_load      = 1'b1;
                end
            end
            ST_STF, ST_LTF_GI, ST_LTF, ST_TAIL: begin
                if (w_fire) begin
                    w_load    = 1'b1;
                    w_rem_nxt = r_rem - REM_W'(1);
                    if (r_rem == REM_W'(1)) begin
                        w_state_nxt = ST_DONE;
                    end else if (r_cnt == w_sec_last) begin
                        w_cnt_nxt = '0;
                        case (r_state)
                            ST_STF:    w_state_nxt = r_ltf ? ST_LTF_GI : ST_AFTER;
                            ST_LTF_GI: w_state_nxt = ST_LTF;
                            default:   w_state_nxt = ST_AFTER;
                        endcase
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        // abort has priority over everything, including a same-cycle start
        if (i_abort) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_rem_nxt   = '0;
            w_ltf_nxt   = 1'b0;
            w_load      = 1'b0;
        end
    end

    // ROM is addressed by the next position so the output register loads
    // the sample that will be presented after this edge.
    always_comb begin
        w_rom_sec = SEC_STF;
        w_rom_idx = '0;
        w_half    = 1'b0;
        case (w_state_nxt)
            ST_STF: begin
                w_rom_idx = {2'b00, w_cnt_nxt[3:0]};
`ifdef WIFI_PRE_WINDOW_EN
                w_half    = (r_state == ST_IDLE);
`endif
            end
            ST_LTF_GI: begin
                w_rom_sec = SEC_LTF;
                w_rom_idx = {1'b1, w_cnt_nxt[4:0]};
            end
            ST_LTF: begin
                w_rom_sec = SEC_LTF;
                w_rom_idx = w_cnt_nxt[5:0];
            end
            ST_TAIL: begin
                w_rom_sec = r_ltf ? SEC_LTF : SEC_STF;
                w_rom_idx = '0;
                w_half    = 1'b1;
            end
            default: ;
        endcase
    end

    wifi_tx_preamble_rom u_rom (
        .i_sec (w_rom_sec),
        .i_idx (w_rom_idx),
        .o_re  (w_rom_re),
        .o_im  (w_rom_im)
    );

    assign w_ext_re  = DATA_W'(w_rom_re) <<< SHIFT;
    assign w_ext_im  = DATA_W'(w_rom_im) <<< SHIFT;
    assign w_data_st = (w_state_nxt == ST_STF) || (w_state_nxt == ST_LTF_GI) ||
                       (w_state_nxt == ST_LTF) || (w_state_nxt == ST_TAIL);

    always_comb begin
        w_re_nxt = '0;
        w_im_nxt = '0;
        if (w_data_st) begin
            if (w_half) begin
                w_re_nxt = w_ext_re >>> 1;
                w_im_nxt = w_ext_im >>> 1;
            end else begin
                w_re_nxt = w_ext_re;
                w_im_nxt = w_ext_im;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_ltf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rem   <= w_rem_nxt;
            r_ltf   <= w_ltf_nxt;
            if (w_load || i_abort) begin
                r_out_valid <= w_data_st;
                r_out_re    <= w_re_nxt;
                r_out_im    <= w_im_nxt;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_re    = r_out_re;
    assign o_out_im    = r_out_im;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_DONE);
    assign o_data_req  = (r_state != ST_IDLE) && (r_rem <= LEAD_C);

endmodule
